// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
// Contents:
//   RAM_DATA_SIZE   byte-address width of the backing RAM
//   SRAM_DATA_BIT   line width in bits
//   SRAM_ADDR_BIT   line address width
//   SRAM_RD_LAT     SRAM read latency in cycles
//   sram_arb_port_e requester port IDs (IF / MEM)
//   sram_arb_state_e arbiter FSM encodings
package sram_port_arbiter_pkg;

  localparam int unsigned RAM_DATA_SIZE = 21;
  localparam int unsigned SRAM_DATA_BIT = 256;
  localparam int unsigned SRAM_ADDR_BIT = RAM_DATA_SIZE - $clog2(SRAM_DATA_BIT / 8);
  localparam int unsigned SRAM_RD_LAT   = 1;

  typedef enum logic {
    SRAM_ARB_PORT_IF  = 1'b0,
    SRAM_ARB_PORT_MEM = 1'b1
  } sram_arb_port_e;

  typedef enum logic {
    SRAM_ARB_IDLE    = 1'b0,
    SRAM_ARB_RD_WAIT = 1'b1
  } sram_arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the IF and MEM requesters.
// Build option: define SRAM_ARB_RR_EN for round-robin on ties; default is
// fixed priority MEM > IF.
// Ports:
//   if_req_i, mem_req_i  request lines
//   last_port_i          port granted most recently (round-robin pointer)
//   pick_en_i            selection allowed this cycle
//   if_pick_o, mem_pick_o one-hot (or zero) winner
module sram_arb_pick
  import sram_port_arbiter_pkg::*;
(
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic last_port_i,
  input  logic pick_en_i,
  output logic if_pick_o,
  output logic mem_pick_o
);

`ifndef SRAM_ARB_RR_EN
  // Pointer only matters for round-robin.
  logic unused_last_port;
  assign unused_last_port = last_port_i;
`endif

  // Winner selection
  always_comb begin
    if_pick_o  = 1'b0;
    mem_pick_o = 1'b0;
    if (pick_en_i) begin
      if (if_req_i && mem_req_i) begin
`ifdef SRAM_ARB_RR_EN
        // Tie goes to the port not granted most recently.
        if (last_port_i == SRAM_ARB_PORT_MEM) begin
          if_pick_o = 1'b1;
        end else begin
          mem_pick_o = 1'b1;
        end
`else
        mem_pick_o = 1'b1;
`endif
      end else if (mem_req_i) begin
        mem_pick_o = 1'b1;
      end else if (if_req_i) begin
        if_pick_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one line-wide SRAM port between the IF and MEM cache refill paths.
// Writes may issue every cycle; a read blocks further grants until its data
// returns, so at most one read is in flight. Grants and the SRAM command are
// combinational from the winning request; rvalid/rdata are registered.
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration (see sram_arb_pick).
// Ports:
//   clk_sys_i, rst_n_i                      clock, async active-low reset
//   if_req_i/if_wea_i/if_addr_i/if_wdata_i  IF request and payload
//   if_gnt_o/if_rvalid_o/if_rdata_o         IF grant and read response
//   mem_*                                   same for the MEM port
//   sram_ena_o/sram_wea_o/sram_addr_o/sram_wdata_o  SRAM command
//   sram_rdata_i                            SRAM read line, SRAM_RD_LAT after ena
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned SRAM_DATA_BIT = sram_port_arbiter_pkg::SRAM_DATA_BIT,
  parameter int unsigned SRAM_ADDR_BIT = sram_port_arbiter_pkg::SRAM_ADDR_BIT,
  parameter int unsigned SRAM_RD_LAT   = sram_port_arbiter_pkg::SRAM_RD_LAT
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     if_req_i,
  input  logic                     if_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] if_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] if_wdata_i,
  output logic                     if_gnt_o,
  output logic                     if_rvalid_o,
  output logic [SRAM_DATA_BIT-1:0] if_rdata_o,
  input  logic                     mem_req_i,
  input  logic                     mem_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] mem_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] mem_wdata_i,
  output logic                     mem_gnt_o,
  output logic                     mem_rvalid_o,
  output logic [SRAM_DATA_BIT-1:0] mem_rdata_o,
  output logic                     sram_ena_o,
  output logic                     sram_wea_o,
  output logic [SRAM_ADDR_BIT-1:0] sram_addr_o,
  output logic [SRAM_DATA_BIT-1:0] sram_wdata_o,
  input  logic [SRAM_DATA_BIT-1:0] sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(SRAM_RD_LAT + 1);

  sram_arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  sram_arb_port_e           rd_port_q;
  sram_arb_port_e           last_port_q;
  logic                     if_pick, mem_pick;
  logic                     pick_en;
  logic                     rd_grant;
  logic                     rd_done;
  logic                     if_rvalid_q, mem_rvalid_q;
  logic [SRAM_DATA_BIT-1:0] if_rdata_q, mem_rdata_q;

  assign pick_en  = (state_q == SRAM_ARB_IDLE);
  assign rd_grant = (if_pick & ~if_wea_i) | (mem_pick & ~mem_wea_i);
  // Counter holds SRAM_RD_LAT in the first wait cycle; data is on sram_rdata_i when it reads 1.
  assign rd_done  = (state_q == SRAM_ARB_RD_WAIT) && (cnt_q == CNT_W'(1));

  sram_arb_pick u_pick (
    .if_req_i    (if_req_i),
    .mem_req_i   (mem_req_i),
    .last_port_i (last_port_q),
    .pick_en_i   (pick_en),
    .if_pick_o   (if_pick),
    .mem_pick_o  (mem_pick)
  );

  // State register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SRAM_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SRAM_ARB_IDLE:    if (rd_grant) state_d = SRAM_ARB_RD_WAIT;
      SRAM_ARB_RD_WAIT: if (rd_done)  state_d = SRAM_ARB_IDLE;
      default:          state_d = SRAM_ARB_IDLE;
    endcase
  end

  // Grant and SRAM command mux; idle bus drives zeros
  always_comb begin
    if_gnt_o     = if_pick;
    mem_gnt_o    = mem_pick;
    sram_ena_o   = if_pick | mem_pick;
    sram_wea_o   = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (mem_pick) begin
      sram_wea_o   = mem_wea_i;
      sram_addr_o  = mem_addr_i;
      sram_wdata_o = mem_wdata_i;
    end else if (if_pick) begin
      sram_wea_o   = if_wea_i;
      sram_addr_o  = if_addr_i;
      sram_wdata_o = if_wdata_i;
    end
  end

  // Latency counter, read owner and round-robin pointer
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      rd_port_q   <= SRAM_ARB_PORT_IF;
      last_port_q <= SRAM_ARB_PORT_IF;
    end else begin
      if (rd_grant) begin
        cnt_q     <= CNT_W'(SRAM_RD_LAT);
        rd_port_q <= mem_pick ? SRAM_ARB_PORT_MEM : SRAM_ARB_PORT_IF;
      end else if (state_q == SRAM_ARB_RD_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (if_pick || mem_pick) begin
        last_port_q <= mem_pick ? SRAM_ARB_PORT_MEM : SRAM_ARB_PORT_IF;
      end
    end
  end

  // Read response capture; rdata holds until the port's next read completes
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if_rvalid_q  <= rd_done && (rd_port_q == SRAM_ARB_PORT_IF);
      mem_rvalid_q <= rd_done && (rd_port_q == SRAM_ARB_PORT_MEM);
      if (rd_done && (rd_port_q == SRAM_ARB_PORT_IF)) begin
        if_rdata_q <= sram_rdata_i;
      end
      if (rd_done && (rd_port_q == SRAM_ARB_PORT_MEM)) begin
        mem_rdata_q <= sram_rdata_i;
      end
    end
  end

  assign if_rvalid_o  = if_rvalid_q;
  assign mem_rvalid_o = mem_rvalid_q;
  assign if_rdata_o   = if_rdata_q;
  assign mem_rdata_o  = mem_rdata_q;

endmodule
